// File: rtl/eqed_inject_ctrl.sv
// eqed_inject_ctrl: sequences a single-bit-flip campaign over every instrumented flip-flop and records which flips corrupt a MISR signature
module eqed_inject_ctrl #(
  parameter int NUM_FF  = 8,
  parameter int IDX_W   = 3,
  parameter int SIG_W   = 6,
  parameter int WIN     = 5,
  parameter int RST_CYC = 2,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  inj_cycle,
  input  logic [SIG_W-1:0]  gold_in,
  input  logic [SIG_W-1:0]  gold_out,
  input  logic [SIG_W-1:0]  in_sig,
  input  logic [SIG_W-1:0]  out_sig,
  output logic              dut_rst,
  output logic [NUM_FF-1:0] inj_sel,
  output logic              busy,
  output logic              done,
  output logic [NUM_FF-1:0] detect_map,
  output logic [IDX_W-1:0]  cur_idx
);
  typedef enum logic [2:0] {IDLE, RESET, RUN, CHECK, DONE} state_t;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, off_q, off_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SIG_W-1:0]   gin_q, gin_d, gout_q, gout_d;
  logic [NUM_FF-1:0]  map_q, map_d, inj_q, inj_d;
  logic               dut_rst_q, dut_rst_d, busy_q, busy_d, done_q, done_d;
  assign dut_rst    = dut_rst_q;
  assign inj_sel    = inj_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign detect_map = map_q;
  assign cur_idx    = idx_q;
  // State and output registers; outputs are computed from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      off_q     <= '0;
      idx_q     <= '0;
      gin_q     <= '0;
      gout_q    <= '0;
      map_q     <= '0;
      inj_q     <= '0;
      dut_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      off_q     <= off_d;
      idx_q     <= idx_d;
      gin_q     <= gin_d;
      gout_q    <= gout_d;
      map_q     <= map_d;
      inj_q     <= inj_d;
      dut_rst_q <= dut_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
  // Campaign sequencing: cnt counts reset cycles in RESET and window cycles in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    off_d   = off_q;
    idx_d   = idx_q;
    gin_d   = gin_q;
    gout_d  = gout_q;
    map_d   = map_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = RESET;
          off_d   = (inj_cycle >= CNT_W'(WIN)) ? CNT_W'(WIN - 1) : inj_cycle;
          gin_d   = gold_in;
          gout_d  = gold_out;
          map_d   = '0;
          idx_d   = '0;
        end
      end
      RESET: if (cnt_q == CNT_W'(RST_CYC - 1)) begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: if (cnt_q == CNT_W'(WIN - 1)) state_d = CHECK;
      CHECK: begin
        map_d[idx_q] = (in_sig != gin_q) || (out_sig != gout_q);
        cnt_d        = '0;
        if (idx_q == IDX_W'(NUM_FF - 1)) state_d = DONE;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = RESET;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // Output decode; the inject select only fires inside RUN so the DUT is never flipped while held in reset
  always_comb begin
    dut_rst_d = !(state_d == RUN || state_d == CHECK);
    busy_d    = state_d == RESET || state_d == RUN || state_d == CHECK;
    done_d    = state_d == DONE;
    inj_d     = (state_d == RUN && cnt_d == off_d) ? NUM_FF'(1) << idx_d : '0;
  end
endmodule

// File: tb/tb_eqed_inject_ctrl.sv
// tb_eqed_inject_ctrl: directed bench for the bit-flip campaign controller
module tb_eqed_inject_ctrl;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] inj_cycle = '0;
  logic [5:0] gold_in = '0, gold_out = '0, in_sig, out_sig;
  logic       dut_rst, busy, done;
  logic [7:0] inj_sel, detect_map;
  logic [2:0] cur_idx;
  int checks = 0, failures = 0;
  logic [5:0] g_in = 6'b111010, g_out = 6'b110010;
  logic [7:0] mask = '0;
  logic       c_in = 1'b0, c_out = 1'b0, hit = 1'b0;
  int         pulse_t[8];
  int         pulse_n, bad_n, done_t, done_n, idx_back;
  logic [7:0] map_done;

  eqed_inject_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .inj_cycle(inj_cycle),
    .gold_in(gold_in), .gold_out(gold_out), .in_sig(in_sig), .out_sig(out_sig),
    .dut_rst(dut_rst), .inj_sel(inj_sel), .busy(busy), .done(done),
    .detect_map(detect_map), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  // Instrumented-design stand-in: a flip on a masked FF corrupts the chosen signature until the next DUT reset
  always @(posedge clk) hit <= dut_rst ? 1'b0 : (hit | (|(inj_sel & mask)));
  assign in_sig  = (hit && c_in)  ? g_in ^ 6'h20  : g_in;
  assign out_sig = (hit && c_out) ? g_out ^ 6'h01 : g_out;

  task automatic run(input logic [3:0] ic, input bit restart);
    int prev;
    bit rs;
    for (int i = 0; i < 8; i++) pulse_t[i] = -1;
    pulse_n = 0; bad_n = 0; done_t = -1; done_n = 0; idx_back = 0; map_done = '0;
    prev = 0; rs = 0;
    start = 1'b1; inj_cycle = ic; gold_in = g_in; gold_out = g_out;
    @(negedge clk);
    start = 1'b0; inj_cycle = 4'hf; gold_in = ~g_in; gold_out = ~g_out;
    for (int t = 1; t <= 80; t++) begin
      start = 1'b0;
      if (inj_sel != '0) begin
        pulse_n++;
        if (!$onehot(inj_sel) || dut_rst) bad_n++;
        for (int i = 0; i < 8; i++) if (inj_sel == (8'd1 << i) && pulse_t[i] < 0) pulse_t[i] = t;
      end
      if (done) begin
        done_n++;
        if (done_t < 0) begin done_t = t; map_done = detect_map; end
      end
      if (busy && int'(cur_idx) < prev) idx_back++;
      if (busy) prev = int'(cur_idx);
      if (restart && !rs && busy && cur_idx == 3'd4) begin start = 1'b1; rs = 1; end
      @(negedge clk);
    end
    start = 1'b0; gold_in = g_in; gold_out = g_out;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; inj_cycle = 4'd2;
    repeat (3) @(negedge clk);
    checks++; if (dut_rst !== 1'b1) begin failures++; $display("FAIL reset_dut_rst got=%b exp=1", dut_rst); end
    checks++; if (inj_sel !== 8'h00) begin failures++; $display("FAIL reset_inj_sel got=%h exp=00", inj_sel); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (detect_map !== 8'h00) begin failures++; $display("FAIL reset_map got=%h exp=00", detect_map); end
    checks++; if (cur_idx !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", cur_idx); end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_start_ignored busy got=%b exp=0", busy); end
  endtask

  task automatic test_golden;
    mask = 8'h00; c_in = 1'b0; c_out = 1'b0;
    run(4'd2, 1'b0);
    checks++; if (done_t != 65) begin failures++; $display("FAIL golden_done_time got=%0d exp=65", done_t); end
    checks++; if (done_n != 1) begin failures++; $display("FAIL golden_done_count got=%0d exp=1", done_n); end
    checks++; if (pulse_n != 8) begin failures++; $display("FAIL golden_pulse_count got=%0d exp=8", pulse_n); end
    checks++; if (bad_n != 0) begin failures++; $display("FAIL golden_bad_pulses got=%0d exp=0", bad_n); end
    checks++; if (map_done !== 8'h00) begin failures++; $display("FAIL golden_map got=%h exp=00", map_done); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (pulse_t[i] != 8 * i + 5) begin failures++; $display("FAIL golden_pulse_ff%0d got=%0d exp=%0d", i, pulse_t[i], 8 * i + 5); end
    end
  endtask

  task automatic test_corrupt;
    mask = 8'h48; c_in = 1'b0; c_out = 1'b1;
    run(4'd1, 1'b0);
    checks++; if (map_done !== 8'h48) begin failures++; $display("FAIL corrupt_map got=%h exp=48", map_done); end
    checks++; if (done_t != 65) begin failures++; $display("FAIL corrupt_done_time got=%0d exp=65", done_t); end
    checks++; if (pulse_t[3] != 28) begin failures++; $display("FAIL corrupt_pulse_ff3 got=%0d exp=28", pulse_t[3]); end
    checks++; if (detect_map !== 8'h48) begin failures++; $display("FAIL corrupt_map_hold got=%h exp=48", detect_map); end
  endtask

  task automatic test_clamp;
    mask = 8'h00; c_in = 1'b0; c_out = 1'b0;
    run(4'd9, 1'b0);
    checks++; if (bad_n != 0) begin failures++; $display("FAIL clamp_bad_pulses got=%0d exp=0", bad_n); end
    checks++; if (pulse_n != 8) begin failures++; $display("FAIL clamp_pulse_count got=%0d exp=8", pulse_n); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (pulse_t[i] != 8 * i + 7) begin failures++; $display("FAIL clamp_pulse_ff%0d got=%0d exp=%0d", i, pulse_t[i], 8 * i + 7); end
    end
  endtask

  task automatic test_busy_start;
    mask = 8'h81; c_in = 1'b1; c_out = 1'b0;
    run(4'd0, 1'b1);
    checks++; if (done_n != 1) begin failures++; $display("FAIL busy_done_count got=%0d exp=1", done_n); end
    checks++; if (done_t != 65) begin failures++; $display("FAIL busy_done_time got=%0d exp=65", done_t); end
    checks++; if (idx_back != 0) begin failures++; $display("FAIL busy_idx_restart got=%0d exp=0", idx_back); end
    checks++; if (map_done !== 8'h81) begin failures++; $display("FAIL busy_map got=%h exp=81", map_done); end
    checks++; if (pulse_t[7] != 59) begin failures++; $display("FAIL busy_pulse_ff7 got=%0d exp=59", pulse_t[7]); end
  endtask

  task automatic test_abort;
    bit found;
    int dn;
    mask = 8'h48; c_in = 1'b0; c_out = 1'b1;
    start = 1'b1; inj_cycle = 4'd2; gold_in = g_in; gold_out = g_out;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int t = 0; t < 100 && !found; t++) begin
      if (cur_idx == 3'd5 && !dut_rst) found = 1;
      else @(negedge clk);
    end
    checks++; if (!found) begin failures++; $display("FAIL abort_reach_ff5 got=0 exp=1"); end
    checks++; if (detect_map !== 8'h08) begin failures++; $display("FAIL abort_partial_map got=%h exp=08", detect_map); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (dut_rst !== 1'b1) begin failures++; $display("FAIL abort_dut_rst got=%b exp=1", dut_rst); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (detect_map !== 8'h00) begin failures++; $display("FAIL abort_map got=%h exp=00", detect_map); end
    checks++; if (cur_idx !== 3'd0) begin failures++; $display("FAIL abort_idx got=%0d exp=0", cur_idx); end
    checks++; if (inj_sel !== 8'h00) begin failures++; $display("FAIL abort_inj_sel got=%h exp=00", inj_sel); end
    dn = 0;
    for (int t = 0; t < 70; t++) begin
      if (done || busy) dn++;
      @(negedge clk);
    end
    checks++; if (dn != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", dn); end
    mask = 8'h00;
    run(4'd2, 1'b0);
    checks++; if (done_t != 65) begin failures++; $display("FAIL abort_rerun_done got=%0d exp=65", done_t); end
    checks++; if (pulse_t[0] != 5) begin failures++; $display("FAIL abort_rerun_ff0 got=%0d exp=5", pulse_t[0]); end
    checks++; if (map_done !== 8'h00) begin failures++; $display("FAIL abort_rerun_map got=%h exp=00", map_done); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_golden;
    test_corrupt;
    test_clamp;
    test_busy_start;
    test_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eqed_inject_ctrl.md
Name: eqed_inject_ctrl

Overview:
- Campaign controller that sits directly upstream of the E-QED-instrumented design module and its input/output MISRs.
- Replaces the free-running binary select with a sequenced single-bit-flip campaign. For each instrumented flip-flop it:
  - resets the DUT and MISRs;
  - drives a one-cycle one-hot inject select at a programmed cycle offset;
  - compares the MISR signatures against golden values at the end of the capture window.
- Produces a per-flip-flop detect bitmap.

Parameters:
- NUM_FF, 8, number of instrumented flip-flops; equals the width of the inject select.
- IDX_W, 3, width of the flip-flop index; ceil(log2(NUM_FF)).
- SIG_W, 6, MISR signature width.
- WIN, 5, capture window in cycles after DUT reset deassertion.
- RST_CYC, 2, number of cycles dut_rst is held high per run; must be ≥1.
- CNT_W, 4, width of the window counter and inj_cycle; must hold WIN.

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- start  in  1  single-cycle campaign start request
- inj_cycle  in  CNT_W  injection offset within the window; sampled on an accepted start
- gold_in  in  SIG_W  golden input-MISR signature; sampled on an accepted start
- gold_out  in  SIG_W  golden output-MISR signature; sampled on an accepted start
- in_sig  in  SIG_W  live input-MISR value
- out_sig  in  SIG_W  live output-MISR value
- dut_rst  out  1  reset to the DUT and both MISRs
- inj_sel  out  NUM_FF  one-hot bit-flip select to the eqed_mux instances
- busy  out  1  campaign in progress
- done  out  1  single-cycle pulse when the campaign completes
- detect_map  out  NUM_FF  bit i = 1 if the flip on FF i corrupted a signature
- cur_idx  out  IDX_W  index of the FF currently under test

Behaviour:
- Reset values: dut_rst=1, inj_sel=0, busy=0, done=0, detect_map=0, cur_idx=0. FSM enters IDLE.
- Reset asserted mid-campaign:
  - aborts immediately and returns to IDLE;
  - partial detect_map is cleared;
  - no done pulse is issued.
- FSM states: IDLE, RESET, RUN, CHECK, DONE. All outputs are registered.
- IDLE:
  - dut_rst=1, busy=0.
  - start=1 → latch inj_cycle, gold_in and gold_out.
  - Clamp the latched offset to WIN-1 if inj_cycle ≥ WIN.
  - Clear detect_map, set cur_idx=0, set busy=1, go to RESET.
- RESET:
  - dut_rst=1 for exactly RST_CYC cycles, then go to RUN with cnt=0.
- RUN:
  - dut_rst=0. The first RUN cycle is cnt=0, and cnt increments every cycle.
  - inj_sel = (1<<cur_idx) only in the cycle where cnt == latched offset; otherwise inj_sel=0.
  - Exactly one select bit is high for exactly one cycle per run.
  - When cnt == WIN-1, go to CHECK.
- CHECK (one cycle; this cycle is cnt == WIN):
  - detect_map[cur_idx] <= (in_sig != gold_in) || (out_sig != gold_out).
  - dut_rst stays 0 during CHECK.
  - If cur_idx == NUM_FF-1: go to DONE.
  - Otherwise: cur_idx+1, go to RESET.
- DONE (one cycle):
  - done=1, busy=0, dut_rst=1, then return to IDLE.
  - detect_map holds its value until the next accepted start or rst.
- start is ignored while busy=1 and in DONE.
- start in the same cycle as rst: rst wins.
- Per-FF run length: RST_CYC + WIN + 1 cycles.
- Campaign length: NUM_FF × (RST_CYC + WIN + 1) + 1 cycles, measured from start to the done pulse. With default parameters this is 65 cycles.
- cur_idx wraps only by returning to IDLE; it never exceeds NUM_FF-1.
- inj_sel is forced to 0 outside RUN, so no injection occurs during dut_rst.

Test Plan:
- Reset: hold rst 3 cycles → dut_rst=1, inj_sel=0, busy=0, done=0, detect_map=0x00, cur_idx=0.
- Golden match (DUT modelled so signatures always equal gold_in=6'b111010, gold_out=6'b110010), start with inj_cycle=2:
  - inj_sel pulses 0x01, 0x02 … 0x80, one cycle each, at cnt=2 of each run;
  - done pulses exactly 65 cycles after start;
  - detect_map=0x00.
- Selective corruption: model forces out_sig mismatch only when FF 3 or FF 6 was flipped → detect_map=0x48 at done.
- Clamp: inj_cycle=9 with WIN=5 → every pulse occurs at cnt=4; no inj_sel activity during dut_rst=1.
- Start while busy: second start pulse during cur_idx=4 → no restart; cur_idx continues 5, 6, 7; a single done pulse.
- Abort: rst asserted during RUN of cur_idx=5 → next cycle in IDLE, dut_rst=1, detect_map=0x00, no done pulse. A subsequent start then runs the full campaign from cur_idx=0.
